// File: rtl/datapath_ctrl.sv
// -----------------------------------------------------------------------------
// datapath_ctrl
//
// Sequencing FSM that sits directly upstream of the lab datapath (register
// file, shifter, ALU, A/B/C/status registers). It accepts one command per
// start pulse and drives every datapath control input cycle by cycle. done
// pulses for one cycle when the command completes.
//
// Commands (cmd):
//   00 MOVI : R[rd] = imm
//   01 MOVR : R[rd] = shift(R[rm], sh)
//   10 ALU  : R[rd] = R[rn] <alu_op> shift(R[rm], sh)
//   11 CMP  : status <= R[rn] - shift(R[rm], sh)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; returns the FSM to WAIT
//   start        command request, sampled only in WAIT
//   cmd          command code (see above)
//   alu_op       ALU operation for cmd=ALU (00 add, 01 sub, 10 and, 11 not-B)
//   rn, rm, rd   first operand / shifted operand / destination registers
//   sh           shift code applied to the B operand
//   imm          immediate for MOVI
//   busy         high in every state except WAIT
//   done         one-cycle completion pulse
//   datapath_in  immediate driven into the datapath write-back mux
//   vsel         1 = write datapath_in, 0 = write C
//   writenum     register-file write address
//   readnum      register-file read address
//   write        register-file write enable
//   loada/loadb/loadc/loads  A, B, C and status register enables
//   asel, bsel   operand source selects (asel=1 zeroes the A operand)
//   shift        shifter control
//   ALUop        ALU control
//
// Optional build macro:
//   DATAPATH_CTRL_STATUS_ON_ALU_EN - when defined, EXEC of an ALU command also
//   asserts loads together with loadc so the status flag tracks every ALU
//   result. When undefined only CMP updates status.
//
// All outputs are decodes of registered state (FSM state plus the command
// fields latched on acceptance); no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module datapath_ctrl #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cmd,
    input  logic [1:0]        alu_op,
    input  logic [REG_W-1:0]  rn,
    input  logic [REG_W-1:0]  rm,
    input  logic [REG_W-1:0]  rd,
    input  logic [1:0]        sh,
    input  logic [DATA_W-1:0] imm,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] datapath_in,
    output logic              vsel,
    output logic [REG_W-1:0]  writenum,
    output logic [REG_W-1:0]  readnum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop
);

    localparam logic [1:0] CMD_MOVI = 2'b00;
    localparam logic [1:0] CMD_MOVR = 2'b01;
    localparam logic [1:0] CMD_ALU  = 2'b10;
    localparam logic [1:0] CMD_CMP  = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_LOAD_A    = 3'd1,
        S_LOAD_B    = 3'd2,
        S_EXEC      = 3'd3,
        S_WRITE_IMM = 3'd4,
        S_WRITE_RES = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t state_q, state_d;

    // Latched command fields; only these copies drive outputs while busy.
    logic [1:0]        cmd_q,    cmd_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic [REG_W-1:0]  rn_q,     rn_d;
    logic [REG_W-1:0]  rm_q,     rm_d;
    logic [REG_W-1:0]  rd_q,     rd_d;
    logic [1:0]        sh_q,     sh_d;
    logic [DATA_W-1:0] imm_q,    imm_d;

    logic accept;

    // -------------------------------------------------------------------------
    // State and command-field registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_WAIT;
            cmd_q    <= '0;
            alu_op_q <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            sh_q     <= '0;
            imm_q    <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            alu_op_q <= alu_op_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            rd_q     <= rd_d;
            sh_q     <= sh_d;
            imm_q    <= imm_d;
        end
    end

    // -------------------------------------------------------------------------
    // Command capture: fields are taken only when a start is accepted in WAIT
    // -------------------------------------------------------------------------
    always_comb begin
        accept   = (state_q == S_WAIT) && start;
        cmd_d    = cmd_q;
        alu_op_d = alu_op_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        rd_d     = rd_q;
        sh_d     = sh_q;
        imm_d    = imm_q;
        if (accept) begin
            cmd_d    = cmd;
            alu_op_d = alu_op;
            rn_d     = rn;
            rm_d     = rm;
            rd_d     = rd;
            sh_d     = sh;
            imm_d    = imm;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT: begin
                if (start) begin
                    unique case (cmd)
                        CMD_MOVI: state_d = S_WRITE_IMM;
                        CMD_MOVR: state_d = S_LOAD_B;
                        default:  state_d = S_LOAD_A;
                    endcase
                end
            end
            S_LOAD_A:    state_d = S_LOAD_B;
            S_LOAD_B:    state_d = S_EXEC;
            // CMP only updates status, so it skips the write-back state.
            S_EXEC:      state_d = (cmd_q == CMD_CMP) ? S_DONE : S_WRITE_RES;
            S_WRITE_IMM: state_d = S_DONE;
            S_WRITE_RES: state_d = S_DONE;
            S_DONE:      state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (Moore): everything defaults to 0, including addresses
    // -------------------------------------------------------------------------
    always_comb begin
        busy        = (state_q != S_WAIT);
        done        = 1'b0;
        datapath_in = '0;
        vsel        = 1'b0;
        writenum    = '0;
        readnum     = '0;
        write       = 1'b0;
        loada       = 1'b0;
        loadb       = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        shift       = '0;
        ALUop       = '0;

        unique case (state_q)
            S_WAIT: ;
            S_LOAD_A: begin
                readnum = rn_q;
                loada   = 1'b1;
            end
            S_LOAD_B: begin
                readnum = rm_q;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = sh_q;
                bsel  = 1'b0;
                // MOVR zeroes the A operand so the ALU passes the shifted B.
                asel  = (cmd_q == CMD_MOVR);
                unique case (cmd_q)
                    CMD_ALU: ALUop = alu_op_q;
                    CMD_CMP: ALUop = ALU_SUB;
                    default: ALUop = ALU_ADD;
                endcase
                if (cmd_q == CMD_CMP) begin
                    loads = 1'b1;
                end else begin
                    loadc = 1'b1;
`ifdef DATAPATH_CTRL_STATUS_ON_ALU_EN
                    loads = (cmd_q == CMD_ALU);
`else
                    loads = 1'b0;
`endif
                end
            end
            S_WRITE_IMM: begin
                vsel        = 1'b1;
                datapath_in = imm_q;
                writenum    = rd_q;
                write       = 1'b1;
            end
            S_WRITE_RES: begin
                vsel     = 1'b0;
                writenum = rd_q;
                write    = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// -----------------------------------------------------------------------------
// tb_datapath_ctrl
//
// Self-checking bench for datapath_ctrl. A small behavioural datapath
// (register file, shifter, ALU, A/B/C/Z) is driven by the controller outputs;
// expected per-cycle control vectors are built from the command rules, and
// expected register/status contents come from plain arithmetic on a golden
// register array.
// -----------------------------------------------------------------------------
module tb_datapath_ctrl;

    localparam int DW = 16;
    localparam int RW = 3;

`ifdef DATAPATH_CTRL_STATUS_ON_ALU_EN
    localparam bit STATUS_ON_ALU = 1'b1;
`else
    localparam bit STATUS_ON_ALU = 1'b0;
`endif

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [DW-1:0] din;
        logic          vsel;
        logic [RW-1:0] wnum;
        logic [RW-1:0] rnum;
        logic          write;
        logic          la;
        logic          lb;
        logic          lc;
        logic          ls;
        logic          asel;
        logic          bsel;
        logic [1:0]    shift;
        logic [1:0]    aluop;
    } ctl_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    cmd;
    logic [1:0]    alu_op;
    logic [RW-1:0] rn, rm, rd;
    logic [1:0]    sh;
    logic [DW-1:0] imm;
    logic          busy, done;
    logic [DW-1:0] datapath_in;
    logic          vsel;
    logic [RW-1:0] writenum, readnum;
    logic          write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]    shift, ALUop;

    datapath_ctrl #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .alu_op(alu_op),
        .rn(rn), .rm(rm), .rd(rd), .sh(sh), .imm(imm),
        .busy(busy), .done(done), .datapath_in(datapath_in), .vsel(vsel),
        .writenum(writenum), .readnum(readnum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural datapath driven by the controller ----------
    logic [DW-1:0] rf [8] = '{default: '0};
    logic [DW-1:0] a_r = '0, b_r = '0, c_r = '0;
    logic          z_r = 1'b0;
    logic [DW-1:0] ain, bin, alu_out;

    always_comb begin
        ain = asel ? '0 : a_r;
        case (shift)
            2'b00:   bin = b_r;
            2'b01:   bin = {b_r[DW-2:0], 1'b0};
            2'b10:   bin = {1'b0, b_r[DW-1:1]};
            default: bin = {b_r[DW-1], b_r[DW-1:1]};
        endcase
        if (bsel) bin = '0;
        case (ALUop)
            2'b00:   alu_out = ain + bin;
            2'b01:   alu_out = ain - bin;
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
    end

    always @(posedge clk) begin
        if (write) rf[writenum] <= vsel ? datapath_in : c_r;
        if (loada) a_r <= rf[readnum];
        if (loadb) b_r <= rf[readnum];
        if (loadc) c_r <= alu_out;
        if (loads) z_r <= (alu_out == '0);
    end

    // ---------------- golden state and counters ------------------------------
    logic [DW-1:0] g [8] = '{default: '0};
    bit            gz = 1'b0;
    bit            gz_known = 1'b0;
    int            tests = 0;
    int            fails = 0;

    function automatic ctl_t obs();
        ctl_t o;
        o = {busy, done, datapath_in, vsel, writenum, readnum,
             write, loada, loadb, loadc, loads, asel, bsel, shift, ALUop};
        return o;
    endfunction

    task automatic chk_ctl(input string tag, input ctl_t o, input ctl_t e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_val(input string tag, input int o, input int e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Enable exclusivity: only ALU EXEC with the status build may pair loadc+loads.
    task automatic chk_enables(input string tag);
        int n;
        n = $countones({write, loada, loadb, loadc, loads});
        tests++;
        assert (n <= 1 || (STATUS_ON_ALU && n == 2 && loadc && loads)) else begin
            fails++;
            $error("FAIL %s_enables observed=%0d expected<=1", tag, n);
        end
    endtask

    task automatic scramble_inputs();
        start  = 1'($urandom);
        cmd    = 2'($urandom);
        alu_op = 2'($urandom);
        rn     = RW'($urandom);
        rm     = RW'($urandom);
        rd     = RW'($urandom);
        sh     = 2'($urandom);
        imm    = DW'($urandom);
    endtask

    function automatic logic [DW-1:0] gshift(input logic [DW-1:0] v, input logic [1:0] s);
        case (s)
            2'b00:   return v;
            2'b01:   return DW'(v * 2);
            2'b10:   return v / 2;
            default: return DW'($signed(v) >>> 1);
        endcase
    endfunction

    function automatic int latency_of(input logic [1:0] c);
        case (c)
            2'b00:   return 2;
            2'b01:   return 4;
            2'b10:   return 5;
            default: return 4;
        endcase
    endfunction

    // Run one command from its WAIT/start cycle through DONE, then step into WAIT.
    task automatic do_cmd(input string tag, input logic [1:0] c, input logic [1:0] op,
                          input logic [RW-1:0] n, input logic [RW-1:0] m,
                          input logic [RW-1:0] d, input logic [1:0] s,
                          input logic [DW-1:0] im);
        ctl_t q[$];
        ctl_t e;
        logic [DW-1:0] bval, res;
        int lat;

        // expected schedule from the command rules
        if (c[1]) begin
            e = '0; e.busy = 1; e.rnum = n; e.la = 1; q.push_back(e);
        end
        if (c != 2'b00) begin
            e = '0; e.busy = 1; e.rnum = m; e.lb = 1; q.push_back(e);
            e = '0; e.busy = 1; e.shift = s; e.asel = (c == 2'b01);
            e.aluop = (c == 2'b10) ? op : (c == 2'b11) ? 2'b01 : 2'b00;
            e.lc = (c != 2'b11);
            e.ls = (c == 2'b11) || (STATUS_ON_ALU && c == 2'b10);
            q.push_back(e);
            if (c != 2'b11) begin
                e = '0; e.busy = 1; e.wnum = d; e.write = 1; q.push_back(e);
            end
        end else begin
            e = '0; e.busy = 1; e.vsel = 1; e.din = im; e.wnum = d; e.write = 1;
            q.push_back(e);
        end
        e = '0; e.busy = 1; e.done = 1; q.push_back(e);

        start = 1'b1; cmd = c; alu_op = op; rn = n; rm = m; rd = d; sh = s; imm = im;
        chk_ctl({tag, "_wait"}, obs(), '0);
        lat = 0;
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk); #1;
            scramble_inputs();
            chk_ctl($sformatf("%s_c%0d", tag, i + 1), obs(), q[i]);
            chk_enables(tag);
            if (done && lat == 0) lat = i + 1;
        end
        chk_val({tag, "_latency"}, lat, latency_of(c));
        start = 1'b0;
        @(posedge clk); #1;

        // golden arithmetic
        bval = gshift(g[m], s);
        case (c)
            2'b00: g[d] = im;
            2'b01: g[d] = bval;
            2'b10: begin
                case (op)
                    2'b00:   res = g[n] + bval;
                    2'b01:   res = g[n] - bval;
                    2'b10:   res = g[n] & bval;
                    default: res = ~bval;
                endcase
                g[d] = res;
                if (STATUS_ON_ALU) begin gz = (res == '0); gz_known = 1'b1; end
            end
            default: begin
                gz = ((g[n] - bval) == '0);
                gz_known = 1'b1;
            end
        endcase
        if (c != 2'b11) chk_val({tag, "_rd"}, int'(rf[d]), int'(g[d]));
        if (gz_known) chk_val({tag, "_z"}, int'(z_r), int'(gz));
    endtask

    initial begin
        logic [RW-1:0] abort_rd;

        // Reset with start held high: stays idle, nothing written
        reset = 1'b1;
        scramble_inputs();
        start = 1'b1;
        cmd   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk_ctl("reset_idle", obs(), '0);
        end
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        chk_ctl("post_reset_idle", obs(), '0);
        chk_val("reset_no_write", int'(rf[0]), 0);

        // Directed sequence
        do_cmd("movi_r2", 2'b00, 2'b00, 3'd0, 3'd0, 3'd2, 2'b00, 16'd202);
        do_cmd("movi_r4", 2'b00, 2'b00, 3'd0, 3'd0, 3'd4, 2'b00, 16'd51);
        do_cmd("movr_r5", 2'b01, 2'b00, 3'd0, 3'd4, 3'd5, 2'b01, 16'd0);
        chk_val("movr_r5_value", int'(rf[5]), 102);
        do_cmd("alu_add_r3", 2'b10, 2'b00, 3'd2, 3'd4, 3'd3, 2'b00, 16'd0);
        chk_val("alu_add_r3_value", int'(rf[3]), 253);
        do_cmd("cmp_r2_r2", 2'b11, 2'b00, 3'd2, 3'd2, 3'd7, 2'b00, 16'd0);
        chk_val("cmp_z", int'(z_r), 1);

        // Reset during EXEC of an ALU command, with start toggled while busy
        abort_rd = 3'd6;
        start = 1'b1; cmd = 2'b10; alu_op = 2'b00; rn = 3'd2; rm = 3'd4;
        rd = abort_rd; sh = 2'b00; imm = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = ~start;
            cmd = 2'b00;
        end
        chk_val("abort_in_exec", int'(loadc), 1);
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk_ctl("abort_wait", obs(), '0);
        @(posedge clk); #1;
        chk_ctl("abort_still_wait", obs(), '0);
        chk_val("abort_no_write", int'(rf[abort_rd]), int'(g[abort_rd]));
        if (STATUS_ON_ALU) gz_known = 1'b0;
        do_cmd("movi_after_abort", 2'b00, 2'b00, 3'd0, 3'd0, 3'd1, 2'b00, 16'hBEEF);

        // Randomised commands, mostly back-to-back with occasional idle cycles
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b0;
                @(posedge clk); #1;
                chk_ctl("idle", obs(), '0);
            end
            do_cmd($sformatf("rnd%0d", k), 2'($urandom), 2'($urandom),
                   RW'($urandom), RW'($urandom), RW'($urandom), 2'($urandom),
                   DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Sequencing FSM directly upstream of the lab datapath (register file, shifter, ALU, A/B/C/status registers).
- Accepts one command per start pulse: move-immediate, move-shifted-register, ALU op, or compare.
- Drives every datapath control input cycle by cycle and pulses done when the command completes.
- Replaces hand-driven control in benches and is the future decode-stage target.

Parameters:
- DATA_W, 16, datapath word width (width of imm and datapath_in)
- REG_W, 3, register-number width (8 registers)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  command request; sampled only in WAIT
- cmd  input  2  00 MOVI, 01 MOVR, 10 ALU, 11 CMP
- alu_op  input  2  ALU operation for cmd=ALU (00 add, 01 sub, 10 and, 11 not-B)
- rn  input  REG_W  first operand register
- rm  input  REG_W  second operand register, passes through the shifter
- rd  input  REG_W  destination register
- sh  input  2  shift code applied to B
- imm  input  DATA_W  immediate for MOVI
- busy  output  1  high in every state except WAIT
- done  output  1  one-cycle pulse in DONE
- datapath_in  output  DATA_W  immediate to datapath
- vsel  output  1  1 = write datapath_in, 0 = write C
- writenum, readnum  output  REG_W  register-file addresses
- write, loada, loadb, loadc, loads  output  1  register enables
- asel, bsel  output  1  operand source selects
- shift  output  2  shifter control
- ALUop  output  2  ALU control

Behaviour:
- Moore FSM. All outputs are registered state decodes with no combinational path from inputs.
- States: WAIT, LOAD_A, LOAD_B, EXEC, WRITE_IMM, WRITE_RES, DONE.
- Reset (any state, including mid-command) -> WAIT. In WAIT every output is 0.
- WAIT with start=1: latch cmd, alu_op, rn, rm, rd, sh and imm. Next state:
  - MOVI -> WRITE_IMM
  - MOVR -> LOAD_B
  - ALU, CMP -> LOAD_A
- While busy, start and all command inputs are ignored. Only the latched copies drive outputs.
- LOAD_A: readnum=rn, loada=1 -> LOAD_B.
- LOAD_B: readnum=rm, loadb=1 -> EXEC.
- EXEC: shift=sh, bsel=0, asel=(cmd==MOVR). ALUop:
  - MOVR: 00
  - ALU: alu_op
  - CMP: 01 (forced)
- EXEC enables:
  - MOVR and ALU: loadc=1, loads=0, next WRITE_RES.
  - CMP: loads=1, loadc=0, next DONE.
- WRITE_IMM: vsel=1, datapath_in=imm, writenum=rd, write=1 -> DONE.
- WRITE_RES: vsel=0, writenum=rd, write=1 -> DONE.
- DONE: done=1, write and all load enables 0 -> WAIT.
- Latency from the start cycle to the done cycle:
  - MOVI: 2 cycles
  - MOVR: 4 cycles
  - ALU: 5 cycles
  - CMP: 4 cycles
- Back-to-back commands: start high in the cycle after DONE is accepted, giving one WAIT cycle between commands.
- Outputs not listed for a state are 0. readnum and writenum hold 0 outside their states.
- At most one of write/loada/loadb/loadc/loads is high in any cycle.
- rd equal to rn or rm is legal. The source registers are read before the write, so no hazard handling is needed.

Optional Feature:
- Macro: DATAPATH_CTRL_STATUS_ON_ALU_EN.
- Defined: EXEC for cmd=ALU also asserts loads=1 together with loadc=1, so Z tracks every ALU result. This is the single exception to the one-enable-per-cycle rule.
- Undefined: only CMP updates status.
- MOVR and MOVI never assert loads in either build.

Test Plan:
- Reset then idle: hold reset 2 cycles with start=1 -> busy=0, done=0, all enables 0, no write observed.
- MOVI rd=2 imm=202: start 1 cycle -> next cycle vsel=1, write=1, writenum=2, datapath_in=202; done pulses the cycle after; datapath R2=202.
- MOVR rd=5 rm=4 sh=01 with R4=51: -> LOAD_B readnum=4; EXEC asel=1, shift=01, loadc=1; WRITE_RES writenum=5; R5=102; done at cycle 4.
- ALU add rd=3 rn=2 rm=4 sh=00 (R2=202, R4=51): -> states LOAD_A, LOAD_B, EXEC, WRITE_RES, DONE; R3=253; loads stays 0 without the macro and is 1 in EXEC with it.
- CMP rn=2 rm=2: -> ALUop=01 and loads=1 in EXEC; write never asserted; Z_out=1; done at cycle 4.
- Reset asserted during EXEC of an ALU command, plus start toggled while busy: -> WAIT next cycle with all outputs 0, no write to rd, mid-command start ignored, a new MOVI accepted normally afterwards.
